// File: rtl/spi_eeprom_pkg.sv
// Shared constants for the SPI EEPROM responder: opcodes, FSM states and
// status register layout.
package spi_eeprom_pkg;

    // Instruction opcodes understood by the responder
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    // Frame-level FSM states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CMD    = 3'd1;
    localparam state_t ST_ADDR   = 3'd2;
    localparam state_t ST_WDATA  = 3'd3;
    localparam state_t ST_RDATA  = 3'd4;
    localparam state_t ST_RDSR   = 3'd5;
    localparam state_t ST_IGNORE = 3'd6;

    // Status register bit positions
    localparam int SR_WIP = 0;
    localparam int SR_WEL = 1;

    // Assemble the status byte returned by RDSR
    function automatic logic [7:0] statusByte(input logic wel, input logic wip);
        logic [7:0] s;
        s         = 8'h00;
        s[SR_WEL] = wel;
        s[SR_WIP] = wip;
        return s;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for an asynchronous SPI pin, followed by a third
// flop that turns the synchronized level into single-clock edge pulses.
module spi_pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the pin and keep one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_eeprom_slave.sv
// SPI mode-0 responder emulating a small 25AA010A-style EEPROM: instruction
// decode, page buffer, single-burst array commit and a timed write cycle.
module spi_eeprom_slave
    import spi_eeprom_pkg::*;
#(
    parameter int MEM_DEPTH    = 128,
    parameter int PAGE_SIZE    = 16,
    parameter int WRITE_CYCLES = 250000
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic spi_csn,
    input  logic spi_sck,
    input  logic spi_si,
    output logic spi_so,
    output logic spi_so_oe,
    output logic wel,
    output logic wip
);

    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int PAGE_BITS = $clog2(PAGE_SIZE);
    localparam int CNT_W     = $clog2(WRITE_CYCLES + 1);

    logic w_sckRise, w_sckFall, w_csnRise, w_csnFall;
    logic r_siMeta, r_siSync;

    state_t              r_state;
    logic [2:0]          r_bitCnt;
    logic [6:0]          r_shiftIn;
    logic [6:0]          r_shiftOut;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_isWrite;
    logic                r_pendValid;
    logic                r_pendSet;
    logic                r_wrAny;
    logic                r_commit;
    logic                r_so;
    logic                r_soOe;
    logic                r_wel;
    logic                r_wip;
    logic [CNT_W-1:0]    r_wipCnt;
    logic [PAGE_SIZE-1:0] r_valid;
    logic [7:0]          r_pageBuf [PAGE_SIZE];
    // Array is stored inverted so a zero-initialised RAM reads back as 0xFF
    logic [7:0]          r_memN    [MEM_DEPTH];

    logic [7:0]           w_nextByte;
    logic                 w_byteDone;
    logic [PAGE_BITS-1:0] w_pageIdx;
    logic [7:0]           w_loadByte;
    logic                 w_wrByte;
    logic [ADDR_W-1:0]    w_addrNext;

    spi_pin_sync #(.RESET_VAL(1'b0)) u_sckSync (
        .clk    (clk_50M),
        .reset  (reset),
        .i_pin  (spi_sck),
        .o_rise (w_sckRise),
        .o_fall (w_sckFall)
    );

    spi_pin_sync #(.RESET_VAL(1'b1)) u_csnSync (
        .clk    (clk_50M),
        .reset  (reset),
        .i_pin  (spi_csn),
        .o_rise (w_csnRise),
        .o_fall (w_csnFall)
    );

    // SI only needs its level, aligned with the SCK edge pulses
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_siMeta <= 1'b0;
            r_siSync <= 1'b0;
        end else begin
            r_siMeta <= spi_si;
            r_siSync <= r_siMeta;
        end
    end

    assign w_nextByte = {r_shiftIn, r_siSync};
    assign w_byteDone = (r_bitCnt == 3'd7);
    assign w_pageIdx  = r_addr[PAGE_BITS-1:0];
    assign w_loadByte = (r_state == ST_RDSR) ? statusByte(r_wel, r_wip) : ~r_memN[r_addr];
    assign w_addrNext = (r_addr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : r_addr + ADDR_W'(1);
    assign w_wrByte   = w_sckRise & ~w_csnRise & ~w_csnFall & (r_state == ST_WDATA) & w_byteDone;

    // Frame FSM: CSN events take priority over SCK, then bit shifting and decode
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bitCnt    <= 3'd0;
            r_shiftIn   <= 7'd0;
            r_shiftOut  <= 7'd0;
            r_addr      <= '0;
            r_isWrite   <= 1'b0;
            r_pendValid <= 1'b0;
            r_pendSet   <= 1'b0;
            r_wrAny     <= 1'b0;
            r_commit    <= 1'b0;
            r_so        <= 1'b0;
            r_soOe      <= 1'b0;
            r_valid     <= '0;
        end else begin
            r_commit <= 1'b0;
            if (w_csnRise) begin
                r_state     <= ST_IDLE;
                r_so        <= 1'b0;
                r_soOe      <= 1'b0;
                r_pendValid <= 1'b0;
                if (r_state == ST_WDATA && r_wrAny && r_bitCnt == 3'd0) begin
                    r_commit <= 1'b1;
                end
            end else if (w_csnFall) begin
                r_state     <= ST_CMD;
                r_bitCnt    <= 3'd0;
                r_shiftIn   <= 7'd0;
                r_pendValid <= 1'b0;
                r_wrAny     <= 1'b0;
                r_valid     <= '0;
                r_so        <= 1'b0;
                r_soOe      <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (w_sckRise) begin
                    r_bitCnt  <= r_bitCnt + 3'd1;
                    r_shiftIn <= w_nextByte[6:0];
                    if (r_state == ST_IGNORE) begin
                        r_pendValid <= 1'b0;
                    end
                    if (w_byteDone) begin
                        case (r_state)
                            ST_CMD: begin
                                if (r_wip && w_nextByte != OP_RDSR) begin
                                    r_state <= ST_IGNORE;
                                end else begin
                                    case (w_nextByte)
                                        OP_WREN: begin
                                            r_state     <= ST_IGNORE;
                                            r_pendValid <= 1'b1;
                                            r_pendSet   <= 1'b1;
                                        end
                                        OP_WRDI: begin
                                            r_state     <= ST_IGNORE;
                                            r_pendValid <= 1'b1;
                                            r_pendSet   <= 1'b0;
                                        end
                                        OP_RDSR: r_state <= ST_RDSR;
                                        OP_READ: begin
                                            r_state   <= ST_ADDR;
                                            r_isWrite <= 1'b0;
                                        end
                                        OP_WRITE: begin
                                            r_state   <= r_wel ? ST_ADDR : ST_IGNORE;
                                            r_isWrite <= 1'b1;
                                        end
                                        default: r_state <= ST_IGNORE;
                                    endcase
                                end
                            end
                            ST_ADDR: begin
                                r_addr  <= w_nextByte[ADDR_W-1:0];
                                r_state <= r_isWrite ? ST_WDATA : ST_RDATA;
                            end
                            ST_WDATA: begin
                                r_valid[w_pageIdx] <= 1'b1;
                                r_addr  <= {r_addr[ADDR_W-1:PAGE_BITS], w_pageIdx + PAGE_BITS'(1)};
                                r_wrAny <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end else if (w_sckFall && (r_state == ST_RDATA || r_state == ST_RDSR)) begin
                    r_soOe <= 1'b1;
                    if (r_bitCnt == 3'd0) begin
                        r_so       <= w_loadByte[7];
                        r_shiftOut <= w_loadByte[6:0];
                        if (r_state == ST_RDATA) begin
                            r_addr <= w_addrNext;
                        end
                    end else begin
                        r_so       <= r_shiftOut[6];
                        r_shiftOut <= {r_shiftOut[5:0], 1'b0};
                    end
                end
            end
        end
    end

    // Capture each completed write byte into the page buffer
    always_ff @(posedge clk_50M) begin
        if (w_wrByte) begin
            r_pageBuf[w_pageIdx] <= w_nextByte;
        end
    end

    // Write-enable latch and the timed write-in-progress window
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            r_wel    <= 1'b0;
            r_wip    <= 1'b0;
            r_wipCnt <= '0;
        end else begin
            if (r_commit) begin
                r_wip    <= 1'b1;
                r_wipCnt <= CNT_W'(WRITE_CYCLES - 1);
            end else if (r_wip) begin
                if (r_wipCnt == '0) begin
                    r_wip <= 1'b0;
                    r_wel <= 1'b0;
                end else begin
                    r_wipCnt <= r_wipCnt - CNT_W'(1);
                end
            end
            if (w_csnRise && r_pendValid) begin
                r_wel <= r_pendSet;
            end
        end
    end

    // Single-cycle burst of every valid buffered byte into the array
    always_ff @(posedge clk_50M) begin
        if (r_commit && !reset) begin
            for (int i = 0; i < PAGE_SIZE; i++) begin
                if (r_valid[i]) begin
                    r_memN[{r_addr[ADDR_W-1:PAGE_BITS], PAGE_BITS'(i)}] <= ~r_pageBuf[i];
                end
            end
        end
    end

    assign spi_so    = r_so;
    assign spi_so_oe = r_soOe;
    assign wel       = r_wel;
    assign wip       = r_wip;

endmodule

// File: tb/tb_spi_eeprom_slave.sv
// Scoreboard bench for spi_eeprom_slave: a bit-banged SPI master drives
// directed frames, expected read bytes are queued, and an SO monitor pops
// and compares each byte the DUT shifts out.
module tb_spi_eeprom_slave;

    localparam int HALF = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic csn   = 1'b1;
    logic sck   = 1'b0;
    logic si    = 1'b0;
    logic so, soOe, wel, wip;

    typedef struct {
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t expQ[$];
    int   vecCount = 0;
    int   missCount = 0;
    int   wipTotal = 0;
    int   oeTotal = 0;
    int   monBits = 0;
    logic [7:0] monByte = 8'h00;

    // 50 MHz system clock
    always #10 clk = ~clk;

    spi_eeprom_slave #(
        .MEM_DEPTH    (128),
        .PAGE_SIZE    (16),
        .WRITE_CYCLES (100)
    ) dut (
        .clk_50M   (clk),
        .reset     (reset),
        .spi_csn   (csn),
        .spi_sck   (sck),
        .spi_si    (si),
        .spi_so    (so),
        .spi_so_oe (soOe),
        .wel       (wel),
        .wip       (wip)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift the top nBits of tx out on SI, mode 0, MSB first
    task automatic applyStimulus(input logic [7:0] tx, input int nBits);
        for (int b = 7; b > 7 - nBits; b--) begin
            si = tx[b];
            waitClocks(HALF);
            sck = 1'b1;
            waitClocks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic frameStart();
        csn = 1'b0;
        waitClocks(HALF);
    endtask

    task automatic frameEnd();
        waitClocks(HALF);
        csn = 1'b1;
        waitClocks(HALF);
    endtask

    // Send nBytes whole bytes, most significant byte of data first
    task automatic sendFrame(input logic [47:0] data, input int nBytes);
        frameStart();
        for (int k = nBytes - 1; k >= 0; k--) begin
            applyStimulus(data[8*k +: 8], 8);
        end
        frameEnd();
    endtask

    task automatic expectByte(input logic [7:0] d, input string n);
        expQ.push_back('{data: d, name: n});
    endtask

    task automatic waitWipClear();
        int n;
        n = 0;
        while (wip && n < 2000) begin
            waitClocks(1);
            n++;
        end
        if (wip) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL wip timeout: got 0x1, expected 0x0");
        end
    endtask

    // Activity counters sampled on the inactive clock edge
    always @(negedge clk) begin
        if (wip)  wipTotal++;
        if (soOe) oeTotal++;
    end

    // SO monitor: assemble bytes at SCK rise while driven, compare against the queue
    always @(posedge sck or posedge csn) begin : soMonitor
        exp_t e;
        if (csn) begin
            monBits = 0;
        end else if (soOe) begin
            monByte = {monByte[6:0], so};
            monBits++;
            if (monBits == 8) begin
                monBits = 0;
                if (expQ.size() == 0) begin
                    vecCount++;
                    missCount++;
                    $display("[TB] FAIL unexpected SO byte: got 0x%0h, expected none", monByte);
                end else begin
                    e = expQ.pop_front();
                    checkOutput(e.name, 32'(monByte), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #4000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w0;
        int o0;
        waitClocks(5);
        reset = 1'b0;
        waitClocks(5);
        checkOutput("reset wel", 32'(wel), 32'd0);
        checkOutput("reset wip", 32'(wip), 32'd0);
        checkOutput("reset so", 32'(so), 32'd0);
        checkOutput("reset so_oe", 32'(soOe), 32'd0);

        $display("[TB] WREN and preload mem[1..2]");
        sendFrame(48'h06, 1);
        checkOutput("wel after WREN", 32'(wel), 32'd1);
        sendFrame(48'h02_01_34_56, 4);
        waitWipClear();

        $display("[TB] WRITE 0x12 at 0x00, READ attempted during wip");
        sendFrame(48'h06, 1);
        w0 = wipTotal;
        sendFrame(48'h02_00_12, 3);
        o0 = oeTotal;
        sendFrame(48'h03_00_00, 3);
        checkOutput("so_oe during wip READ", 32'(oeTotal - o0), 32'd0);
        waitWipClear();
        checkOutput("wip length", 32'(wipTotal - w0), 32'd100);
        checkOutput("wel after commit", 32'(wel), 32'd0);

        expectByte(8'h12, "read mem[0]");
        expectByte(8'h34, "read mem[1]");
        expectByte(8'h56, "read mem[2]");
        sendFrame(48'h03_00_00_00_00, 5);

        $display("[TB] read address wrap");
        sendFrame(48'h06, 1);
        sendFrame(48'h02_7F_5A, 3);
        waitWipClear();
        expectByte(8'h5A, "read mem[0x7F]");
        expectByte(8'h12, "read wrap mem[0]");
        sendFrame(48'h03_7F_00_00, 4);

        $display("[TB] WRITE without WREN");
        w0 = wipTotal;
        sendFrame(48'h02_00_99, 3);
        waitClocks(150);
        checkOutput("no-WREN wip", 32'(wipTotal - w0), 32'd0);
        checkOutput("no-WREN wel", 32'(wel), 32'd0);
        expectByte(8'h12, "no-WREN mem[0]");
        sendFrame(48'h03_00_00, 3);

        $display("[TB] page wrap write and RDSR polling");
        sendFrame(48'h06, 1);
        sendFrame(48'h02_0E_A1_A2_A3_A4, 6);
        expectByte(8'h03, "RDSR during wip");
        expectByte(8'h00, "RDSR after expiry");
        sendFrame(48'h05_00_00, 3);
        waitWipClear();
        expectByte(8'hA1, "page mem[0x0E]");
        expectByte(8'hA2, "page mem[0x0F]");
        sendFrame(48'h03_0E_00_00, 4);
        expectByte(8'hA3, "page mem[0x00]");
        expectByte(8'hA4, "page mem[0x01]");
        sendFrame(48'h03_00_00_00, 4);

        $display("[TB] WREN off byte boundary, WRDI");
        frameStart();
        applyStimulus(8'h06, 8);
        applyStimulus(8'h00, 1);
        frameEnd();
        checkOutput("WREN 9 bits wel", 32'(wel), 32'd0);
        sendFrame(48'h06, 1);
        checkOutput("wel before WRDI", 32'(wel), 32'd1);
        sendFrame(48'h04, 1);
        checkOutput("wel after WRDI", 32'(wel), 32'd0);

        $display("[TB] partial trailing byte aborts write");
        sendFrame(48'h06, 1);
        w0 = wipTotal;
        frameStart();
        applyStimulus(8'h02, 8);
        applyStimulus(8'h00, 8);
        applyStimulus(8'h55, 8);
        applyStimulus(8'h66, 8);
        applyStimulus(8'h70, 4);
        frameEnd();
        waitClocks(20);
        checkOutput("partial wip", 32'(wipTotal - w0), 32'd0);
        checkOutput("partial wel kept", 32'(wel), 32'd1);

        $display("[TB] reset during WDATA");
        w0 = wipTotal;
        frameStart();
        applyStimulus(8'h02, 8);
        applyStimulus(8'h00, 8);
        applyStimulus(8'h77, 8);
        applyStimulus(8'h78, 4);
        reset = 1'b1;
        waitClocks(3);
        reset = 1'b0;
        waitClocks(1);
        checkOutput("post-reset wel", 32'(wel), 32'd0);
        checkOutput("post-reset wip", 32'(wip), 32'd0);
        checkOutput("post-reset so", 32'(so), 32'd0);
        checkOutput("post-reset so_oe", 32'(soOe), 32'd0);
        frameEnd();
        waitClocks(20);
        checkOutput("post-reset no commit", 32'(wipTotal - w0), 32'd0);
        expectByte(8'hA3, "post-reset mem[0x00]");
        expectByte(8'hA4, "post-reset mem[0x01]");
        sendFrame(48'h03_00_00_00, 4);

        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
